// File: rtl/watch_fnd_ctrl.sv
// -----------------------------------------------------------------------------
// watch_fnd_ctrl
//
// Display back-end for the stopwatch/clock datapath. Takes the centisecond,
// second, minute and hour counters and drives a 4-digit common-anode
// 7-segment (FND) display by time-multiplexed scanning.
//
//   mode 0 : HH.MM   (digit3 digit2 . digit1 digit0)
//   mode 1 : SS.cc
//
// The field selected for editing blinks (blank while msec >= 50) and the
// centre dot (digit2 dp) is lit while msec < 50, giving a 1 Hz blink.
//
// Optional build macro:
//   FND_LEADING_BLANK_EN - when defined, the hour tens digit is blanked in
//                          mode 0 for hours 0..9. Undefined: leading zeros
//                          are always shown.
//
// Parameters:
//   SCAN_COUNT   clk cycles per digit slot (minimum 2)
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active low
//   i_msec       centiseconds, valid 0..99
//   i_sec        seconds, valid 0..59
//   i_min        minutes, valid 0..59
//   i_hour       hours, valid 0..23
//   i_disp_mode  0 = HH.MM, 1 = SS.cc
//   i_edit_sel   edit select {hour, min, sec}; hour > min > sec priority
//   fnd_com      digit enables, active low, one-hot-low
//   fnd_data     segments {dp,g,f,e,d,c,b,a}, active low
// -----------------------------------------------------------------------------
module watch_fnd_ctrl #(
    parameter int unsigned SCAN_COUNT = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] i_msec,
    input  logic [5:0] i_sec,
    input  logic [5:0] i_min,
    input  logic [4:0] i_hour,
    input  logic       i_disp_mode,
    input  logic [2:0] i_edit_sel,
    output logic [3:0] fnd_com,
    output logic [7:0] fnd_data
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int unsigned CW = (SCAN_COUNT > 2) ? $clog2(SCAN_COUNT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_COUNT - 1);

    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Active-low segment pattern for a decimal digit; dp bit left dark.
    function automatic logic [7:0] seg_code(input logic [3:0] digit);
        logic [7:0] code;
        case (digit)
            4'd0:    code = 8'hC0;
            4'd1:    code = 8'hF9;
            4'd2:    code = 8'hA4;
            4'd3:    code = 8'hB0;
            4'd4:    code = 8'h99;
            4'd5:    code = 8'h92;
            4'd6:    code = 8'h82;
            4'd7:    code = 8'hF8;
            4'd8:    code = 8'h80;
            4'd9:    code = 8'h90;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // Tens digit of a field value. Quotients above 9 only arise for
    // out-of-range values, which are shown as a dash, so they saturate.
    function automatic logic [3:0] tens_of(input logic [6:0] value);
        logic [6:0] quot;
        quot = value / 7'd10;
        return (quot > 7'd9) ? 4'd9 : quot[3:0];
    endfunction

    // Ones digit of a field value (remainder is always 0..9).
    function automatic logic [3:0] ones_of(input logic [6:0] value);
        logic [6:0] rem;
        rem = value % 7'd10;
        return (rem > 7'd9) ? 4'd9 : rem[3:0];
    endfunction

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [CW-1:0] cnt_q;
    logic [1:0]    idx_q;
    logic [3:0]    com_q;
    logic [7:0]    data_q;

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    logic          tick_s;
    logic [1:0]    idx_d;
    logic [3:0]    com_d;
    logic [7:0]    data_d;

    logic [6:0]    hi_val_s;
    logic [6:0]    lo_val_s;
    logic          hi_oor_s;
    logic          lo_oor_s;
    logic [3:0]    hi_tens_s;
    logic [3:0]    hi_ones_s;
    logic [3:0]    lo_tens_s;
    logic [3:0]    lo_ones_s;

    logic          blink_off_s;
    logic          sel_hour_s;
    logic          sel_min_s;
    logic          sel_sec_s;
    logic          blank_hi_s;
    logic          blank_lo_s;
    logic          lead_blank_s;

    logic [7:0]    code_s;
    logic          dp_dark_s;
    logic          blank_s;

    assign tick_s = (cnt_q == CNT_MAX);
    assign idx_d  = idx_q + 2'd1;
    assign com_d  = ~(4'b0001 << idx_d);

    // Second half of each msec second: blinking fields go dark, dot goes dark.
    assign blink_off_s = (i_msec >= 7'd50);

    // Edit select priority hour > min > sec.
    assign sel_hour_s = i_edit_sel[2];
    assign sel_min_s  = i_edit_sel[1] & ~i_edit_sel[2];
    assign sel_sec_s  = i_edit_sel[0] & ~i_edit_sel[1] & ~i_edit_sel[2];

    // Field selection for the current display mode.
    always_comb begin
        hi_val_s   = 7'd0;
        lo_val_s   = 7'd0;
        hi_oor_s   = 1'b0;
        lo_oor_s   = 1'b0;
        blank_hi_s = 1'b0;
        blank_lo_s = 1'b0;
        if (i_disp_mode == 1'b0) begin
            hi_val_s   = {2'b00, i_hour};
            lo_val_s   = {1'b0, i_min};
            hi_oor_s   = (i_hour > 5'd23);
            lo_oor_s   = (i_min > 6'd59);
            blank_hi_s = sel_hour_s & blink_off_s;
            blank_lo_s = sel_min_s & blink_off_s;
        end else begin
            // msec is never editable, so only the high (sec) field can blink.
            hi_val_s   = {1'b0, i_sec};
            lo_val_s   = i_msec;
            hi_oor_s   = (i_sec > 6'd59);
            lo_oor_s   = (i_msec > 7'd99);
            blank_hi_s = sel_sec_s & blink_off_s;
            blank_lo_s = 1'b0;
        end
    end

    assign hi_tens_s = tens_of(hi_val_s);
    assign hi_ones_s = ones_of(hi_val_s);
    assign lo_tens_s = tens_of(lo_val_s);
    assign lo_ones_s = ones_of(lo_val_s);

`ifdef FND_LEADING_BLANK_EN
    assign lead_blank_s = (i_disp_mode == 1'b0) && !hi_oor_s && (i_hour < 5'd10);
`else
    assign lead_blank_s = 1'b0;
`endif

    // Segment data for the digit that becomes active at the next scan tick.
    always_comb begin
        code_s    = SEG_BLANK;
        dp_dark_s = 1'b1;
        blank_s   = 1'b0;
        case (idx_d)
            2'd0: begin
                code_s  = lo_oor_s ? SEG_DASH : seg_code(lo_ones_s);
                blank_s = blank_lo_s;
            end
            2'd1: begin
                code_s  = lo_oor_s ? SEG_DASH : seg_code(lo_tens_s);
                blank_s = blank_lo_s;
            end
            2'd2: begin
                code_s    = hi_oor_s ? SEG_DASH : seg_code(hi_ones_s);
                dp_dark_s = blink_off_s;
                blank_s   = blank_hi_s;
            end
            2'd3: begin
                code_s  = hi_oor_s ? SEG_DASH : seg_code(hi_tens_s);
                blank_s = blank_hi_s | lead_blank_s;
            end
            default: begin
                code_s    = SEG_BLANK;
                dp_dark_s = 1'b1;
                blank_s   = 1'b1;
            end
        endcase

        if (blank_s) begin
            data_d = SEG_BLANK;
        end else begin
            data_d = {dp_dark_s, code_s[6:0]};
        end
    end

    // Scan counter: free-running 0..SCAN_COUNT-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (tick_s) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Digit index and output registers, loaded together so enable and data
    // always switch on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q  <= 2'd0;
            com_q  <= 4'b1111;
            data_q <= SEG_BLANK;
        end else if (tick_s) begin
            idx_q  <= idx_d;
            com_q  <= com_d;
            data_q <= data_d;
        end else begin
            idx_q  <= idx_q;
            com_q  <= com_q;
            data_q <= data_q;
        end
    end

    assign fnd_com  = com_q;
    assign fnd_data = data_q;

endmodule

// File: tb/tb_watch_fnd_ctrl.sv
module tb_watch_fnd_ctrl;

    localparam int SC = 4;

    logic       clk;
    logic       rst;
    logic [6:0] i_msec;
    logic [5:0] i_sec;
    logic [5:0] i_min;
    logic [4:0] i_hour;
    logic       i_disp_mode;
    logic [2:0] i_edit_sel;
    logic [3:0] fnd_com;
    logic [7:0] fnd_data;

    int tests_run;
    int tests_failed;
    int cyc;
    logic [11:0] exp_q[$];
    logic [11:0] last_exp;

    watch_fnd_ctrl #(.SCAN_COUNT(SC)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_msec      (i_msec),
        .i_sec       (i_sec),
        .i_min       (i_min),
        .i_hour      (i_hour),
        .i_disp_mode (i_disp_mode),
        .i_edit_sel  (i_edit_sel),
        .fnd_com     (fnd_com),
        .fnd_data    (fnd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side cycle count since reset release; a load is due every SC edges.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

`ifdef FND_LEADING_BLANK_EN
    localparam bit LB = 1'b1;
`else
    localparam bit LB = 1'b0;
`endif

    function automatic logic [3:0] exp_com(input int load_num);
        logic [3:0] one;
        one = 4'b0001;
        if (load_num == 0) return 4'b1111;
        return ~(one << (load_num % 4));
    endfunction

    // Advance to the negedge following the next scan load.
    task automatic wait_load();
        @(negedge clk);
        while (!(cyc != 0 && (cyc % SC) == 0)) @(negedge clk);
    endtask

    // Push the expected frame for the next four loads, then pop and compare.
    task automatic run_frame(input string name, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3);
        logic [7:0]  dig [4];
        logic [11:0] e;
        int          n;
        dig[0] = d0; dig[1] = d1; dig[2] = d2; dig[3] = d3;
        n = cyc / SC + 1;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({exp_com(n + k), dig[(n + k) % 4]});
        end
        for (int k = 0; k < 4; k++) begin
            wait_load();
            e = exp_q.pop_front();
            last_exp = e;
            tests_run++;
            if ({fnd_com, fnd_data} !== e) begin
                tests_failed++;
                $display("FAIL %s load%0d: got com=%b data=%h, expected com=%b data=%h",
                         name, k, fnd_com, fnd_data, e[11:8], e[7:0]);
            end
        end
    endtask

    // Check reset-dark outputs, then the scan sequence after release.
    task automatic check_restart(input string name);
        int n;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            n = c / SC;
            tests_run++;
            if (fnd_com !== exp_com(n)) begin
                tests_failed++;
                $display("FAIL %s_com cycle%0d: got %b, expected %b", name, c, fnd_com, exp_com(n));
            end
            if (n == 0) begin
                tests_run++;
                if (fnd_data !== 8'hFF) begin
                    tests_failed++;
                    $display("FAIL %s_data cycle%0d: got %h, expected ff", name, c, fnd_data);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        i_msec = 7'd0; i_sec = 6'd0; i_min = 6'd0; i_hour = 5'd0;
        i_disp_mode = 1'b0; i_edit_sel = 3'b000;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (fnd_com !== 4'b1111 || fnd_data !== 8'hFF) begin
            tests_failed++;
            $display("FAIL reset_state: got com=%b data=%h, expected 1111/ff", fnd_com, fnd_data);
        end
        rst = 1'b1;
        check_restart("scan");
    endtask

    task automatic test_hhmm();
        i_disp_mode = 1'b0; i_hour = 5'd12; i_min = 6'd34; i_msec = 7'd10; i_edit_sel = 3'b000;
        run_frame("hhmm_12_34", 8'h99, 8'hB0, 8'h24, 8'hF9);
        i_hour = 5'd0; i_min = 6'd0; i_msec = 7'd49;
        run_frame("hhmm_00_00", 8'hC0, 8'hC0, 8'h40, LB ? 8'hFF : 8'hC0);
    endtask

    task automatic test_sscc();
        i_disp_mode = 1'b1; i_sec = 6'd59; i_msec = 7'd75; i_edit_sel = 3'b000;
        run_frame("sscc_59_75", 8'h92, 8'hF8, 8'h90, 8'h92);
        i_sec = 6'd3; i_msec = 7'd99;
        run_frame("sscc_03_99", 8'h90, 8'h90, 8'hB0, 8'hC0);
    endtask

    task automatic test_edit_blink();
        i_disp_mode = 1'b0; i_hour = 5'd9; i_min = 6'd5; i_edit_sel = 3'b100;
        i_msec = 7'd20;
        run_frame("edit_hour_on", 8'h92, 8'hC0, 8'h10, LB ? 8'hFF : 8'hC0);
        i_msec = 7'd60;
        run_frame("edit_hour_off", 8'h92, 8'hC0, 8'hFF, 8'hFF);
        i_edit_sel = 3'b010;
        run_frame("edit_min_off", 8'hFF, 8'hFF, 8'h90, LB ? 8'hFF : 8'hC0);
        i_edit_sel = 3'b110;
        run_frame("edit_prio", 8'h92, 8'hC0, 8'hFF, 8'hFF);
        i_disp_mode = 1'b1; i_sec = 6'd7; i_edit_sel = 3'b001;
        run_frame("edit_sec_off", 8'hC0, 8'h82, 8'hFF, 8'hFF);
    endtask

    task automatic test_out_of_range();
        i_disp_mode = 1'b0; i_hour = 5'd12; i_min = 6'd60; i_msec = 7'd10; i_edit_sel = 3'b000;
        run_frame("oor_min", 8'hBF, 8'hBF, 8'h24, 8'hF9);
        i_disp_mode = 1'b1; i_sec = 6'd7; i_msec = 7'd60; i_edit_sel = 3'b010;
        run_frame("mode1_min_edit", 8'hC0, 8'h82, 8'hF8, 8'hC0);
        i_disp_mode = 1'b0; i_hour = 5'd24; i_min = 6'd34; i_msec = 7'd10; i_edit_sel = 3'b000;
        run_frame("oor_hour", 8'h99, 8'hB0, 8'h3F, 8'hBF);
        i_disp_mode = 1'b1; i_sec = 6'd60; i_msec = 7'd100;
        run_frame("oor_sscc", 8'hBF, 8'hBF, 8'hBF, 8'hBF);
    endtask

    // Inputs changed between loads must not reach the outputs.
    task automatic test_hold();
        i_disp_mode = 1'b0; i_hour = 5'd1; i_min = 6'd2; i_msec = 7'd3; i_edit_sel = 3'b000;
        run_frame("hold_setup", 8'hA4, 8'hC0, 8'h79, LB ? 8'hFF : 8'hC0);
        i_min = 6'd48; i_hour = 5'd17; i_disp_mode = 1'b1;
        for (int c = 0; c < SC - 1; c++) begin
            @(negedge clk);
            tests_run++;
            if ({fnd_com, fnd_data} !== last_exp) begin
                tests_failed++;
                $display("FAIL hold cycle%0d: got com=%b data=%h, expected com=%b data=%h",
                         c, fnd_com, fnd_data, last_exp[11:8], last_exp[7:0]);
            end
        end
    endtask

    task automatic test_mid_reset();
        i_disp_mode = 1'b0; i_hour = 5'd12; i_min = 6'd34; i_msec = 7'd10; i_edit_sel = 3'b000;
        wait_load();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if (fnd_com !== 4'b1111 || fnd_data !== 8'hFF) begin
            tests_failed++;
            $display("FAIL mid_reset_dark: got com=%b data=%h, expected 1111/ff", fnd_com, fnd_data);
        end
        @(negedge clk);
        rst = 1'b1;
        check_restart("restart");
        run_frame("after_restart", 8'h99, 8'hB0, 8'h24, 8'hF9);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        last_exp     = 12'h000;
        test_reset();
        test_hhmm();
        test_sscc();
        test_edit_blink();
        test_out_of_range();
        test_hold();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
